// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture receive path.
package scope_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  localparam int unsigned CH0_LSB     = 0;
  localparam int unsigned CH1_LSB     = 16;
  localparam int unsigned CH_W        = 16;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank simple dual-port frame RAM: one write port, one registered read port.
module frame_bank_ram #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned Words = 1 << AddrW,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_bank_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem [2*Words];
  logic [DataW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  // Array has no reset; only the output register is cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/capture_frame_receiver.sv
// AXI4-Stream capture frame receiver with ping-pong frame buffer and error counters.
// Optional per-channel min/max tracking is enabled by defining FRAME_RX_MINMAX_EN.
module capture_frame_receiver
  import scope_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH      = 10,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN            = 1 << FIFO_ADDR_WIDTH
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic                            frame_ready,
  input  logic                            frame_ack,
  input  logic [FIFO_ADDR_WIDTH-1:0]      rd_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data,
  output logic [FRAME_CNT_W-1:0]          frame_count,
  output logic [ERR_CNT_W-1:0]            short_err_count,
  output logic [ERR_CNT_W-1:0]            long_err_count,
  output logic [1:0]                      state_out,
  output logic [CH_W-1:0]                 ch0_min,
  output logic [CH_W-1:0]                 ch0_max,
  output logic [CH_W-1:0]                 ch1_min,
  output logic [CH_W-1:0]                 ch1_max
);

  rx_state_e                  state_q, state_d;
  logic                       wr_bank_q, wr_bank_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                       frame_ready_q, frame_ready_d;
  logic                       tready_q, tready_d;
  logic [FRAME_CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [ERR_CNT_W-1:0]       short_err_q, short_err_d;
  logic [ERR_CNT_W-1:0]       long_err_q, long_err_d;

  logic accept;
  logic last_word;
  logic swap;
  logic we;

  assign accept    = S_AXIS_TVALID && tready_q;
  assign last_word = &wr_cnt_q;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_cnt_d      = wr_cnt_q;
    frame_ready_d = frame_ready_q;
    frame_cnt_d   = frame_cnt_q;
    short_err_d   = short_err_q;
    long_err_d    = long_err_q;
    swap          = 1'b0;
    we            = 1'b0;

    // Ack is applied first so a frame completing in the same cycle can swap at once.
    if (frame_ack && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end

    unique case (state_q)
      RECV: begin
        if (accept) begin
          we = 1'b1;
          if (S_AXIS_TLAST && !last_word) begin
            if (short_err_q != '1) short_err_d = short_err_q + 1'b1;
            wr_cnt_d = '0;
          end else if (!S_AXIS_TLAST && last_word) begin
            if (long_err_q != '1) long_err_d = long_err_q + 1'b1;
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else if (S_AXIS_TLAST && last_word) begin
            wr_cnt_d = '0;
            if (!frame_ready_q || frame_ack) begin
              swap          = 1'b1;
              frame_ready_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && S_AXIS_TLAST) begin
          wr_cnt_d = '0;
          state_d  = RECV;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          swap          = 1'b1;
          frame_ready_d = 1'b1;
          state_d       = RECV;
        end
      end
      default: state_d = RECV;
    endcase

    if (swap) begin
      wr_bank_d   = ~wr_bank_q;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    // Registered so TREADY is low throughout reset and tracks the state it enters.
    tready_d = (state_d != HOLD);
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q       <= RECV;
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      frame_ready_q <= 1'b0;
      tready_q      <= 1'b0;
      frame_cnt_q   <= '0;
      short_err_q   <= '0;
      long_err_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      frame_ready_q <= frame_ready_d;
      tready_q      <= tready_d;
      frame_cnt_q   <= frame_cnt_d;
      short_err_q   <= short_err_d;
      long_err_q    <= long_err_d;
    end
  end

  // Display bank is always the one not being written.
  frame_bank_ram #(
    .AddrW(FIFO_ADDR_WIDTH),
    .Words(FRAME_LEN),
    .DataW(C_S_AXIS_TDATA_WIDTH)
  ) u_ram (
    .clk_i    (S_AXIS_ACLK),
    .rst_ni   (S_AXIS_ARESETN),
    .we_i     (we),
    .wr_bank_i(wr_bank_q),
    .wr_addr_i(wr_cnt_q),
    .wr_data_i(S_AXIS_TDATA),
    .rd_bank_i(~wr_bank_q),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign S_AXIS_TREADY   = tready_q;
  assign frame_ready     = frame_ready_q;
  assign frame_count     = frame_cnt_q;
  assign short_err_count = short_err_q;
  assign long_err_count  = long_err_q;
  assign state_out       = state_q;

`ifdef FRAME_RX_MINMAX_EN
  logic [1:0][CH_W-1:0] beat_ch;
  logic [1:0][CH_W-1:0] nx_min, nx_max;
  logic [1:0][CH_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [1:0][CH_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
  logic                 first_word;

  assign beat_ch[0] = S_AXIS_TDATA[CH0_LSB +: CH_W];
  assign beat_ch[1] = S_AXIS_TDATA[CH1_LSB +: CH_W];

  always_comb begin
    first_word = (wr_cnt_q == '0);
    nx_min     = '0;
    nx_max     = '0;
    run_min_d  = run_min_q;
    run_max_d  = run_max_q;
    out_min_d  = out_min_q;
    out_max_d  = out_max_q;
    // Word 0 restarts the trackers; every error path returns wr_cnt to 0.
    for (int c = 0; c < 2; c++) begin
      nx_min[c] = (first_word || beat_ch[c] < run_min_q[c]) ? beat_ch[c] : run_min_q[c];
      nx_max[c] = (first_word || beat_ch[c] > run_max_q[c]) ? beat_ch[c] : run_max_q[c];
    end
    if (state_q == RECV && accept) begin
      run_min_d = nx_min;
      run_max_d = nx_max;
    end
    if (swap) begin
      if (state_q == HOLD) begin
        out_min_d = run_min_q;
        out_max_d = run_max_q;
      end else begin
        out_min_d = nx_min;
        out_max_d = nx_max;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      run_min_q <= '0;
      run_max_q <= '0;
      out_min_q <= '0;
      out_max_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
    end
  end

  assign ch0_min = out_min_q[0];
  assign ch0_max = out_max_q[0];
  assign ch1_min = out_min_q[1];
  assign ch1_max = out_max_q[1];
`else
  assign ch0_min = '0;
  assign ch0_max = '0;
  assign ch1_min = '0;
  assign ch1_max = '0;
`endif

endmodule
